input_number_ctrl: RTL and testbench
====================================

// Module: input_number_ctrl
// PURPOSE
// Control FSM for the serial input-number datapath (shift register + bit counter).
// Detects a start bit on serin, pulses the counter initialise, and enables shift and count for exactly N_BITS cycles.
// Cross-checks the datapath carry-out, then presents a valid/ack handshake to the consumer of the parallel word.
// Drives the datapath's iz_cnt, cen and shen inputs directly. Sits between the serial pin and that datapath.
// PARAMETERS
// N_BITS   8   data bits per frame (shift cycles per frame); legal range 2..255
// CNT_W    8   width of internal bit counter; must satisfy 2**CNT_W >= N_BITS
// PORTS
// clk     in   1      system clock, all state on rising edge
// rst     in   1      asynchronous reset, active-low (0 = reset)
// serin   in   1      serial line, idle high; a 0 sampled in IDLE is the start bit
// co      in   1      datapath counter carry-out, combinational, same-cycle
// ack     in   1      consumer has taken the word (meaningful only while valid=1)
// abort   in   1      synchronous abort, returns FSM to IDLE
// iz_cnt  out  1      initialise datapath counter
// cen     out  1      datapath counter enable
// shen    out  1      datapath shift-register enable
// valid   out  1      parallel word in datapath is complete and stable
// busy    out  1      frame in progress (LOAD or SHIFT)
// err     out  1      sticky carry-mismatch flag for current/last frame
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, bit_cnt=0, err=0; all outputs 0.
// - Outputs iz_cnt/cen/shen/valid/busy are Moore, decoded from the state register only.
// - States and transitions (evaluated at rising clk):
//   IDLE : all ctrl outs 0. serin==0 -> LOAD; else stay.
//   LOAD : iz_cnt=1, busy=1, bit_cnt<=0, err<=0. -> SHIFT unconditionally.
//   SHIFT: shen=1, cen=1, busy=1, bit_cnt<=bit_cnt+1.
//          bit_cnt==N_BITS-1 -> DONE; else stay.
//   DONE : valid=1, shen=cen=0 (word frozen). ack==1 -> IDLE; else hold.
// - abort==1 at any edge forces IDLE next cycle; priority over every other transition.
//   err unchanged by abort.
// - Exactly N_BITS cycles with shen=1 per frame; iz_cnt high for exactly 1 cycle.
// - Latency: start bit sampled at edge k -> LOAD during cycle k..k+1.
//   SHIFT spans cycles k+1..k+N_BITS. valid rises after edge k+N_BITS+1.
// - serin is ignored outside IDLE; serin held 0 after DONE->IDLE starts a new frame.
// - ack while not in DONE is ignored. ack held high re-enters IDLE after the frame's DONE cycle.
//   Minimum valid width is 1 cycle.
// - Carry check in SHIFT, per cycle:
//   err<=1 if co==1 while bit_cnt<N_BITS-1, or co==0 while bit_cnt==N_BITS-1.
//   Mismatch does not alter sequencing; the FSM still completes on its own count.
// - err is sticky until the next LOAD; it is visible during DONE and after.
// - bit_cnt never wraps: it only reaches N_BITS-1 inside SHIFT and is cleared in LOAD.
// - Async reset mid-frame: outputs drop immediately. Datapath contents are not reinitialised until the next LOAD.
// - Illegal state encodings decode to IDLE on the next edge.
// TESTING
// 1 Reset: rst=0 mid-SHIFT -> iz_cnt/cen/shen/valid/busy/err all 0 immediately; IDLE after release.
// 2 Nominal frame, N_BITS=8: serin 0 then 8 data bits 1,0,1,1,0,0,1,0; co asserted on 8th shift.
//   -> iz_cnt 1 cycle; shen=cen=1 for exactly 8 cycles; valid=1 9 edges after start sample; err=0.
// 3 Handshake: hold ack=0 for 5 cycles in DONE -> valid stays 1, shen=0.
//   ack=1 -> valid=0 next cycle, state IDLE. serin=0 on that edge -> iz_cnt next cycle.
// 4 Carry mismatch: co forced 1 at 4th shift -> err=1 by DONE; valid still after 8 shifts.
//   Next frame with correct co -> err cleared in LOAD, remains 0.
// 5 Abort: abort=1 at 3rd SHIFT cycle -> shen=cen=busy=0 next cycle, no valid.
//   serin=1 afterwards -> stays IDLE.
// 6 Back-to-back: ack tied 1, serin 0 continuously -> repeating LOAD, 8xSHIFT, DONE, IDLE.
//   Period N_BITS+3=11 cycles; 3 consecutive valid pulses, each 1 cycle.

Source files
------------

// File: rtl/input_number_ctrl.sv
// Control FSM for the serial input-number datapath.
// Sequences start detect, counter init, N_BITS shift cycles and a valid/ack handoff.
module input_number_ctrl #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic serin,
    input  logic co,
    input  logic ack,
    input  logic abort,
    output logic iz_cnt,
    output logic cen,
    output logic shen,
    output logic valid,
    output logic busy,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             last;

    assign last = (bit_cnt == CNT_W'(N_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // co must rise exactly on the final shift; any other pattern is sticky
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            err     <= 1'b0;
        end else if (!abort) begin
            case (state)
                LOAD: begin
                    bit_cnt <= '0;
                    err     <= 1'b0;
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (co != last) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (!abort) begin
            case (state)
                IDLE:    state_nxt = serin ? IDLE : LOAD;
                LOAD:    state_nxt = SHIFT;
                SHIFT:   state_nxt = last ? DONE : SHIFT;
                DONE:    state_nxt = ack ? IDLE : DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        iz_cnt = 1'b0;
        cen    = 1'b0;
        shen   = 1'b0;
        valid  = 1'b0;
        busy   = 1'b0;
        case (state)
            LOAD: begin
                iz_cnt = 1'b1;
                busy   = 1'b1;
            end
            SHIFT: begin
                shen = 1'b1;
                cen  = 1'b1;
                busy = 1'b1;
            end
            DONE:    valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_input_number_ctrl.sv
// Scoreboard bench for input_number_ctrl with a behavioural shift/count datapath.
// Expected words are queued at stimulus time and checked when valid appears.
module tb_input_number_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serin = 1'b1;
    logic ack = 1'b0;
    logic abort = 1'b0;
    logic co_inj = 1'b0;
    logic co;
    logic iz_cnt, cen, shen, valid, busy, err;

    logic [7:0] sr = 8'h00;
    logic [7:0] dp_cnt = 8'h00;

    logic [8:0] sb_q[$];
    logic [8:0] exp_e;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    input_number_ctrl #(.N_BITS(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .serin(serin), .co(co),
        .ack(ack), .abort(abort), .iz_cnt(iz_cnt), .cen(cen),
        .shen(shen), .valid(valid), .busy(busy), .err(err)
    );

    // Datapath stand-in: counter carry is high on its 8th count
    assign co = (dp_cnt == 8'd7) | co_inj;

    always @(posedge clk) begin
        if (shen) sr <= {sr[6:0], serin};
        if (iz_cnt) dp_cnt <= 8'd0;
        else if (cen) dp_cnt <= dp_cnt + 8'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] data, input int inj,
                             input logic exp_err);
        serin = 1'b0;
        step();
        checks++;
        if (iz_cnt !== 1'b1 || busy !== 1'b1 || shen !== 1'b0) begin
            fails++;
            $display("FAIL load: iz_cnt=%b busy=%b shen=%b, want 1 1 0",
                     iz_cnt, busy, shen);
        end
        sb_q.push_back({data, exp_err});
        step();
        for (int i = 0; i < 8; i++) begin
            serin  = data[7-i];
            co_inj = (i == inj - 1);
            checks++;
            if (shen !== 1'b1 || cen !== 1'b1 || iz_cnt !== 1'b0 ||
                valid !== 1'b0) begin
                fails++;
                $display("FAIL shift%0d: shen=%b cen=%b iz=%b valid=%b, want 1 1 0 0",
                         i, shen, cen, iz_cnt, valid);
            end
            if (i == 0) begin
                checks++;
                if (err !== 1'b0) begin
                    fails++;
                    $display("FAIL err_clear: err=%b, want 0", err);
                end
            end
            step();
        end
        co_inj = 1'b0;
        serin  = 1'b1;
        checks++;
        if (valid !== 1'b1 || shen !== 1'b0 || cen !== 1'b0 ||
            busy !== 1'b0) begin
            fails++;
            $display("FAIL done: valid=%b shen=%b cen=%b busy=%b, want 1 0 0 0",
                     valid, shen, cen, busy);
        end
        checks++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: got valid with no expected word");
        end else begin
            exp_e = sb_q.pop_front();
            if ({sr, err} !== exp_e) begin
                fails++;
                $display("FAIL word: word=%h err=%b, want word=%h err=%b",
                         sr, err, exp_e[8:1], exp_e[0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if ({iz_cnt, cen, shen, valid, busy, err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_init: outs=%b, want 000000",
                     {iz_cnt, cen, shen, valid, busy, err});
        end
        step();
        rst = 1'b1;
        step();
        serin = 1'b0;
        step();
        serin = 1'b1;
        step();
        step();
        checks++;
        if (shen !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre: shen=%b, want 1", shen);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({iz_cnt, cen, shen, valid, busy, err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_mid: outs=%b, want 000000",
                     {iz_cnt, cen, shen, valid, busy, err});
        end
        step();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || iz_cnt !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b valid=%b iz=%b, want 0 0 0",
                     busy, valid, iz_cnt);
        end
    endtask

    task automatic test_nominal();
        run_frame(8'b1011_0010, 0, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL nominal_idle: valid=%b busy=%b, want 0 0", valid, busy);
        end
    endtask

    task automatic test_handshake();
        run_frame(8'h5A, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (valid !== 1'b1 || shen !== 1'b0) begin
                fails++;
                $display("FAIL hold%0d: valid=%b shen=%b, want 1 0", i, valid, shen);
            end
        end
        ack   = 1'b1;
        serin = 1'b0;
        step();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || iz_cnt !== 1'b0) begin
            fails++;
            $display("FAIL ack_idle: valid=%b iz=%b, want 0 0", valid, iz_cnt);
        end
        step();
        serin = 1'b1;
        checks++;
        if (iz_cnt !== 1'b1) begin
            fails++;
            $display("FAIL restart: iz_cnt=%b, want 1", iz_cnt);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL restart_abort: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_carry_mismatch();
        run_frame(8'hC3, 4, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
        run_frame(8'h3C, 0, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_abort();
        serin = 1'b0;
        step();
        serin = 1'b1;
        step();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (shen !== 1'b0 || cen !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL abort: shen=%b cen=%b busy=%b valid=%b, want 0 0 0 0",
                     shen, cen, busy, valid);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0) begin
                fails++;
                $display("FAIL abort_idle%0d: busy=%b valid=%b, want 0 0",
                         i, busy, valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int last_c = 0;
        logic prev_v = 1'b0;
        for (int f = 0; f < 3; f++) sb_q.push_back(9'h000);
        ack   = 1'b1;
        serin = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            step();
            if (valid) begin
                checks++;
                if (prev_v) begin
                    fails++;
                    $display("FAIL b2b_width: valid high two cycles at %0d", c);
                end
                checks++;
                if (pulses > 0 && c - last_c != 11) begin
                    fails++;
                    $display("FAIL b2b_period: got %0d, want 11", c - last_c);
                end
                checks++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_sb: unexpected valid at %0d", c);
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({sr, err} !== exp_e) begin
                        fails++;
                        $display("FAIL b2b_word: word=%h err=%b, want %h %b",
                                 sr, err, exp_e[8:1], exp_e[0]);
                    end
                end
                pulses++;
                last_c = c;
            end
            prev_v = valid;
        end
        serin = 1'b1;
        ack   = 1'b0;
        step();
        checks++;
        if (pulses != 3 || last_c != 32) begin
            fails++;
            $display("FAIL b2b_count: pulses=%0d last=%0d, want 3 32", pulses, last_c);
        end
        checks++;
        if (busy !== 1'b0 || sb_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_end: busy=%b pending=%0d, want 0 0", busy, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_handshake();
        test_carry_mismatch();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
